// File: rtl/mii_tx_scheduler.sv
// mii_tx_scheduler: two-source round-robin MII nibble transmitter with preamble/SFD insertion, IFG and underrun abort.
// Build macro MII_TX_MIN_PAD_EN enables zero padding of short frames up to MIN_NIBBLES payload nibbles.
module mii_tx_scheduler #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24,
    parameter int MIN_NIBBLES      = 120,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       src0_valid,
    input  logic       src0_empty,
    input  logic [3:0] src0_d,
    input  logic       src0_last,
    output logic       src0_rd,
    input  logic       src1_valid,
    input  logic       src1_empty,
    input  logic [3:0] src1_d,
    input  logic       src1_last,
    output logic       src1_rd,
    output logic [3:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       grant
);
`ifdef MII_TX_MIN_PAD_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, DRAIN, IFG, PAD} state_t;
`else
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, DRAIN, IFG} state_t;
`endif
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_NIBBLES);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             grant_n, pop;
    logic [3:0]       txd_n;
    logic             tx_en_n, tx_er_n;
    logic             g_empty, g_last;
    logic [3:0]       g_d;
    assign g_empty = grant ? src1_empty : src0_empty;
    assign g_last  = grant ? src1_last : src0_last;
    assign g_d     = grant ? src1_d : src0_d;
    assign src0_rd = ena & pop & ~grant;
    assign src1_rd = ena & pop & grant;
    assign busy    = state != IDLE;
    // Next state, next line outputs and the pop request for the granted source
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant_n = grant;
        txd_n   = 4'h0;
        tx_en_n = 1'b0;
        tx_er_n = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (src0_valid || src1_valid) begin
                    grant_n = (src0_valid && src1_valid) ? ~grant : src1_valid;
                    txd_n   = 4'h5;
                    tx_en_n = 1'b1;
                    cnt_n   = CNT_W'(1);
                    state_n = (PREAMBLE_NIBBLES > 1) ? PREAMBLE : SFD;
                end
            end
            PREAMBLE: begin
                txd_n   = 4'h5;
                tx_en_n = 1'b1;
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == PRE_LAST) ? SFD : PREAMBLE;
            end
            SFD: begin
                txd_n   = 4'hD;
                tx_en_n = 1'b1;
                cnt_n   = '0;
                state_n = DATA;
            end
            DATA: begin
                tx_en_n = 1'b1;
                if (!g_empty) begin
                    pop   = 1'b1;
                    txd_n = g_d;
                    cnt_n = (cnt == MIN_CNT) ? cnt : cnt + 1'b1;
                    if (g_last) begin
`ifdef MII_TX_MIN_PAD_EN
                        state_n = (cnt_n < MIN_CNT) ? PAD : IFG;
                        cnt_n   = (cnt_n < MIN_CNT) ? cnt_n : '0;
`else
                        state_n = IFG;
                        cnt_n   = '0;
`endif
                    end
                end else begin
                    tx_er_n = 1'b1;
                    state_n = DRAIN;
                end
            end
`ifdef MII_TX_MIN_PAD_EN
            PAD: begin
                tx_en_n = 1'b1;
                cnt_n   = cnt + 1'b1;
                if (cnt_n == MIN_CNT) begin
                    state_n = IFG;
                    cnt_n   = '0;
                end
            end
`endif
            DRAIN: begin
                if (!g_empty) begin
                    pop = 1'b1;
                    if (g_last) begin
                        state_n = IFG;
                        cnt_n   = '0;
                    end
                end
            end
            IFG: begin
                cnt_n = cnt + 1'b1;
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // State, counter, grant and registered line outputs advance only on ena
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 1'b1;
            gmii_txd   <= 4'h0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
        end else if (ena) begin
            state      <= state_n;
            cnt        <= cnt_n;
            grant      <= grant_n;
            gmii_txd   <= txd_n;
            gmii_tx_en <= tx_en_n;
            gmii_tx_er <= tx_er_n;
        end
    end
endmodule

// File: tb/tb_mii_tx_scheduler.sv
// tb_mii_tx_scheduler: scoreboard bench for mii_tx_scheduler with show-ahead FIFO models for both sources.
module tb_mii_tx_scheduler;
    localparam int PRE = 15;
    localparam int IFG = 24;
    localparam int MIN = 120;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b0;
    logic       src0_valid, src0_empty, src0_last, src0_rd;
    logic       src1_valid, src1_empty, src1_last, src1_rd;
    logic [3:0] src0_d, src1_d, gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, busy, grant;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] exp_q[$];
    logic       gexp[$];
    int         n0, n1, pops0, pops1, checks, failures, gap;
    logic       force_v0, p0, p1, prev_en, armed;
    logic [5:0] prev_out;

    mii_tx_scheduler dut (
        .clk(clk), .reset(reset), .ena(ena),
        .src0_valid(src0_valid), .src0_empty(src0_empty), .src0_d(src0_d), .src0_last(src0_last), .src0_rd(src0_rd),
        .src1_valid(src1_valid), .src1_empty(src1_empty), .src1_d(src1_d), .src1_last(src1_last), .src1_rd(src1_rd),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic refresh();
        src0_empty = q0.size() == 0;
        src0_d     = src0_empty ? 4'h0 : q0[0][3:0];
        src0_last  = src0_empty ? 1'b0 : q0[0][4];
        src0_valid = force_v0 || n0 != 0;
        src1_empty = q1.size() == 0;
        src1_d     = src1_empty ? 4'h0 : q1[0][3:0];
        src1_last  = src1_empty ? 1'b0 : q1[0][4];
        src1_valid = n1 != 0;
    endtask

    task automatic load(input int s, input int len, input logic [3:0] base, input logic fin);
        logic [4:0] v;
        for (int i = 0; i < len; i++) begin
            v = {fin && (i == len - 1), base + 4'(i)};
            if (s == 0) q0.push_back(v);
            else q1.push_back(v);
        end
        if (fin && s == 0) n0++;
        if (fin && s == 1) n1++;
        refresh();
    endtask

    task automatic exp_frame(input int len, input logic [3:0] base, input logic g);
        for (int i = 0; i < PRE; i++) exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
        for (int i = 0; i < len; i++) exp_q.push_back({1'b0, base + 4'(i)});
`ifdef MII_TX_MIN_PAD_EN
        for (int i = len; i < MIN; i++) exp_q.push_back(5'h00);
`endif
        gexp.push_back(g);
    endtask

    task automatic cycle(input logic e);
        logic [4:0] v;
        ena = e;
        #1;
        p0 = src0_rd;
        p1 = src1_rd;
        if (!e) chk("rd_gated", {30'b0, p0, p1}, 0);
        else if (p0 || p1) chk("rd_other", grant ? p0 : p1, 0);
        @(posedge clk);
        #1;
        if (p0 && q0.size() != 0) begin
            v = q0.pop_front();
            pops0++;
            if (v[4]) n0--;
        end
        if (p1 && q1.size() != 0) begin
            v = q1.pop_front();
            pops1++;
            if (v[4]) n1--;
        end
        refresh();
        if (!e) chk("hold", {gmii_txd, gmii_tx_en, gmii_tx_er}, prev_out);
        else if (gmii_tx_en) begin
            if (!prev_en) begin
                if (armed) chk("ifg_gap", gap, IFG);
                chk("grant_avail", gexp.size() != 0, 1);
                if (gexp.size() != 0) chk("grant", grant, gexp.pop_front());
            end
            chk("nib_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("nibble", {gmii_tx_er, gmii_txd}, exp_q.pop_front());
        end else begin
            chk("er_idle", gmii_tx_er, 0);
            armed = armed || prev_en;
            gap = prev_en ? 1 : gap + 1;
        end
        if (e) prev_en = gmii_tx_en;
        prev_out = {gmii_txd, gmii_tx_en, gmii_tx_er};
        @(negedge clk);
    endtask

    task automatic run(input logic half, input int lim);
        int n;
        n = 0;
        while ((busy || src0_valid || src1_valid || exp_q.size() != 0) && n < lim) begin
            cycle(half ? n[0] : 1'b1);
            n++;
        end
        chk("run_bound", n < lim, 1);
        chk("exp_left", exp_q.size(), 0);
    endtask

    task automatic start();
        pops0 = 0;
        pops1 = 0;
        armed = 1'b0;
        gap = 0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out", {gmii_txd, gmii_tx_en, gmii_tx_er, busy}, 0);
        chk("rst_grant", grant, 1);
        chk("rst_rd", {src0_rd, src1_rd}, 0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        gexp.delete();
        n0 = 0;
        n1 = 0;
        force_v0 = 1'b0;
        refresh();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        prev_en = 1'b0;
        prev_out = '0;
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        n0 = 0;
        n1 = 0;
        force_v0 = 1'b0;
        prev_en = 1'b0;
        prev_out = '0;
        start();
        refresh();
        @(negedge clk);
        do_reset();
        // single frame 0x1..0xA from src0
        start();
        load(0, 10, 4'h1, 1'b1);
        exp_frame(10, 4'h1, 1'b0);
        run(1'b0, 400);
        chk("t1_rd0", pops0, 10);
        chk("t1_rd1", pops1, 0);
        // contention straight out of reset: src0, src1, src0
        do_reset();
        start();
        load(0, 6, 4'h3, 1'b1);
        load(1, 7, 4'h8, 1'b1);
        load(0, 5, 4'hB, 1'b1);
        exp_frame(6, 4'h3, 1'b0);
        exp_frame(7, 4'h8, 1'b1);
        exp_frame(5, 4'hB, 1'b0);
        run(1'b0, 1200);
        chk("t2_rd0", pops0, 11);
        chk("t2_rd1", pops1, 7);
        // underrun after the 4th payload nibble, tail arrives during drain
        start();
        force_v0 = 1'b1;
        load(0, 4, 4'h2, 1'b0);
        for (int i = 0; i < PRE; i++) exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'h2 + 4'(i)});
        exp_q.push_back(5'h10);
        gexp.push_back(1'b0);
        cycle(1'b1);
        force_v0 = 1'b0;
        refresh();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle(1'b1);
        chk("ur_nibbles", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        load(0, 3, 4'h6, 1'b1);
        for (int i = 0; i < 20 && q0.size() != 0; i++) cycle(1'b1);
        chk("ur_drained", q0.size(), 0);
        chk("ur_pops", pops0, 7);
        n = 0;
        while (busy && n < 100) begin
            cycle(1'b1);
            n++;
        end
        chk("ur_ifg", n, IFG);
        // ena every second clock, frame from src1
        start();
        load(1, 9, 4'h4, 1'b1);
        exp_frame(9, 4'h4, 1'b1);
        run(1'b1, 900);
        chk("t4_rd1", pops1, 9);
        chk("t4_rd0", pops0, 0);
        // reset in the middle of the payload, then contention again
        start();
        load(0, 10, 4'h7, 1'b1);
        exp_frame(10, 4'h7, 1'b0);
        n = 0;
        while (pops0 < 5 && n < 200) begin
            cycle(1'b1);
            n++;
        end
        chk("t5_reach", pops0, 5);
        do_reset();
        start();
        load(0, 4, 4'h1, 1'b1);
        load(1, 4, 4'h9, 1'b1);
        exp_frame(4, 4'h1, 1'b0);
        exp_frame(4, 4'h9, 1'b1);
        run(1'b0, 800);
        chk("t5_rd0", pops0, 4);
        chk("t5_rd1", pops1, 4);
        // short 8-nibble frame: padded only in the padding build
        start();
        load(0, 8, 4'h5, 1'b1);
        exp_frame(8, 4'h5, 1'b0);
        run(1'b0, 400);
        chk("t6_rd0", pops0, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mii_tx_scheduler.md
Name: mii_tx_scheduler

Overview:
- Sequences the 4-bit MII/GMII transmit path of the firewall and shares it between two frame sources: src0 (forwarded traffic) and src1 (locally generated frames).
- Round-robin arbitration at frame boundaries. Inserts preamble and SFD, streams the granted source's nibbles, and enforces the inter-frame gap.
- On underrun, signals the error on the line and discards the rest of the frame.
- Sits between the per-source show-ahead nibble FIFOs and the PHY TX pins.

Parameters:
- PREAMBLE_NIBBLES, 15, number of 0x5 nibbles sent before SFD.
- IFG_NIBBLES, 24, minimum tx_en-low ena-cycles between frames (96 bit times).
- MIN_NIBBLES, 120, minimum payload nibbles before the pad stops (60 bytes; used only with the optional feature).
- CNT_W, 8, width of the internal nibble/gap counter; must hold max(PREAMBLE_NIBBLES, IFG_NIBBLES, MIN_NIBBLES).

Ports:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low reset.
- ena, in, 1, nibble strobe; all state and outputs advance only on clk edges with ena=1.
- src0_valid, in, 1, a complete frame is present in the src0 FIFO.
- src0_empty, in, 1, src0 FIFO empty.
- src0_d, in, 4, src0 head nibble (show-ahead).
- src0_last, in, 1, src0 head nibble is the final nibble of its frame.
- src0_rd, out, 1, pop src0 head this cycle (combinational).
- src1_valid, src1_empty, src1_d[3:0], src1_last, src1_rd: same as src0.
- gmii_txd, out, 4, transmit nibble (registered).
- gmii_tx_en, out, 1, transmit enable (registered).
- gmii_tx_er, out, 1, transmit error (registered).
- busy, out, 1, state != IDLE.
- grant, out, 1, index of the source currently or last served.

Behaviour:
- Reset (reset=0, asynchronous):
  - gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, busy=0, grant=1.
  - State=IDLE, counters cleared, src*_rd=0.
  - grant=1 at reset makes src0 win the first contested arbitration.
  - Reset asserted mid-frame truncates the line immediately; there is no drain.
- ena=0: registers hold and src*_rd=0.
- States: IDLE, PREAMBLE, SFD, DATA, PAD (optional feature only), DRAIN, IFG.
- IDLE:
  - Outputs 0.
  - If any srcN_valid is set: choose the one valid source. If both are valid, choose !grant.
  - Update grant, write txd=0x5 and tx_en=1, set cnt=1, go to PREAMBLE.
- PREAMBLE:
  - Each ena writes txd=0x5, tx_en=1.
  - After PREAMBLE_NIBBLES total preamble nibbles, the next ena writes txd=0xD (SFD) and the state goes to DATA.
- DATA, granted source not empty:
  - srcG_rd=1; write txd=srcG_d, tx_en=1, tx_er=0; increment the payload count.
  - If srcG_last, go to IFG (or PAD, see the optional feature).
- DATA, granted source empty (underrun):
  - Write txd=0, tx_en=1, tx_er=1 for exactly one nibble, then go to DRAIN.
- DRAIN:
  - tx_en=0, tx_er=0.
  - srcG_rd=ena & !srcG_empty; discard nibbles.
  - When the popped nibble has last=1, go to IFG.
- IFG:
  - Write tx_en=0, tx_er=0, txd=0 for IFG_NIBBLES ena-cycles, then go to IDLE.
  - A waiting source therefore sees exactly IFG_NIBBLES low cycles before its preamble.
- Latency: srcN_valid high in IDLE gives preamble on the same ena edge. The first payload nibble appears PREAMBLE_NIBBLES+1 ena edges later.
- Valid changes are sampled only in IDLE. A source whose valid rises during another frame waits for IFG completion.
- The non-granted source's rd is always 0. Nibbles are never popped outside DATA/DRAIN.
- Latency is fixed: one data nibble out per DATA ena-cycle, registered one edge after the pop.

Optional Feature:
- Macro: MII_TX_MIN_PAD_EN.
- When defined:
  - On last with payload count < MIN_NIBBLES, go to PAD.
  - PAD writes txd=0, tx_en=1 until the count reaches MIN_NIBBLES, then goes to IFG.
  - Underrun in DATA still goes to DRAIN; no pad follows an aborted frame.
- When undefined: the PAD state and payload counter compare are absent, and frames pass unpadded.

Test Plan:
- Single frame: src0_valid with a 10-nibble frame 0x1..0xA, ena=1 always.
  - Expect 15×0x5, then 0xD, then 0x1..0xA with tx_en=1, then tx_en=0.
  - Expect 10 src0_rd pulses and tx_er=0 throughout.
- Contention: src0 and src1 both valid at reset release.
  - Expect src0 first, a 24-cycle gap, then src1, then src0 again.
  - Expect grant to toggle 0,1,0 and no src1_rd during the src0 frame.
- Underrun: src0_empty rises after the 4th payload nibble, last nibble arrives later.
  - Expect one nibble with tx_en=1, tx_er=1, txd=0, then tx_en=0.
  - Expect the remaining nibbles popped up to last, then 24 IFG cycles.
- ena gating: ena=1 every 2nd clk during a frame.
  - Expect an identical nibble sequence, outputs held on ena=0 cycles, and rd only on ena=1.
- Reset mid-frame: reset=0 during DATA.
  - Expect all outputs 0 asynchronously.
  - After release, src0 and src1 both valid gives src0 first.
- With MII_TX_MIN_PAD_EN: 8-nibble frame.
  - Expect 8 data nibbles plus 112 nibbles of 0x0 with tx_en=1, then IFG.
  - Without the macro, tx_en drops after 8 nibbles.
